// File: rtl/operand_stage.sv
// Decode-to-execute operand register with EX/WB forwarding, load-use stall
// detection and a valid/ready handshake toward the ALU stage.
module operand_stage #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic [4:0]             in_rd,
  input  logic                   in_use_rs1,
  input  logic                   in_use_rs2,
  input  logic                   in_is_load,
  input  logic [XLEN-1:0]        in_imm,
  input  logic [XLEN-1:0]        rf_rdata1,
  input  logic [XLEN-1:0]        rf_rdata2,
  input  logic                   ex_fwd_en,
  input  logic                   ex_load_pend,
  input  logic [4:0]             ex_rd,
  input  logic [XLEN-1:0]        ex_data,
  input  logic                   wb_en,
  input  logic [4:0]             wb_rd,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_op1,
  output logic [XLEN-1:0]        out_op2,
  output logic [XLEN-1:0]        out_imm,
  output logic [4:0]             out_rd,
  output logic                   out_is_load,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic                   valid_q, valid_d;
  logic [XLEN-1:0]        op1_q, op1_d, op2_q, op2_d, imm_q, imm_d;
  logic [4:0]             rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic                   is_load_q, is_load_d, use1_q, use1_d, use2_q, use2_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   hz, xfer;
  logic [XLEN-1:0]        op1_res, op2_res;

  // x0 is hard-wired to zero, so it is never forwarded; EX is younger than WB.
  function automatic logic [XLEN-1:0] resolve(
    input logic [4:0]      idx,
    input logic [XLEN-1:0] rf,
    input logic            ex_en,
    input logic [4:0]      ex_idx,
    input logic [XLEN-1:0] ex_val,
    input logic            wb_v,
    input logic [4:0]      wb_idx,
    input logic [XLEN-1:0] wb_val
  );
    if (idx == 5'd0)                     return '0;
    else if (ex_en && (ex_idx == idx))   return ex_val;
    else if (wb_v && (wb_idx == idx))    return wb_val;
    else                                 return rf;
  endfunction

  always_comb begin
    op1_res  = resolve(in_rs1, rf_rdata1, ex_fwd_en, ex_rd, ex_data, wb_en, wb_rd, wb_data);
    op2_res  = resolve(in_rs2, rf_rdata2, ex_fwd_en, ex_rd, ex_data, wb_en, wb_rd, wb_data);
    hz       = in_valid & ex_load_pend & (ex_rd != 5'd0) &
               ((in_use_rs1 & (ex_rd == in_rs1)) | (in_use_rs2 & (ex_rd == in_rs2)));
    in_ready = ~flush & ~hz & (~valid_q | out_ready);
    xfer     = in_valid & in_ready;

    valid_d   = valid_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    imm_d     = imm_q;
    rd_d      = rd_q;
    is_load_d = is_load_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    use1_d    = use1_q;
    use2_d    = use2_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (xfer) begin
      valid_d   = 1'b1;
      op1_d     = op1_res;
      op2_d     = op2_res;
      imm_d     = in_imm;
      rd_d      = in_rd;
      is_load_d = in_is_load;
      rs1_d     = in_rs1;
      rs2_d     = in_rs2;
      use1_d    = in_use_rs1;
      use2_d    = in_use_rs2;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      // A held instruction would otherwise miss a WB that lands while it waits.
      if (wb_en && (wb_rd != 5'd0) && use1_q && (wb_rd == rs1_q)) op1_d = wb_data;
      if (wb_en && (wb_rd != 5'd0) && use2_q && (wb_rd == rs2_q)) op2_d = wb_data;
    end

    stall_d = stall_q;
    if (hz && !flush && (stall_q != {STALL_CNT_W{1'b1}}))
      stall_d = stall_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
      is_load_q <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      use1_q    <= 1'b0;
      use2_q    <= 1'b0;
      stall_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      imm_q     <= imm_d;
      rd_q      <= rd_d;
      is_load_q <= is_load_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      use1_q    <= use1_d;
      use2_q    <= use2_d;
      stall_q   <= stall_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_op1     = op1_q;
  assign out_op2     = op2_q;
  assign out_imm     = imm_q;
  assign out_rd      = rd_q;
  assign out_is_load = is_load_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: a reference model pushes expected output-register
// contents on each transfer; scenario tasks compare the DUT against the front entry.
module tb_operand_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready, in_use_rs1, in_use_rs2, in_is_load;
  logic [4:0]  in_rs1, in_rs2, in_rd, ex_rd, wb_rd, out_rd;
  logic [31:0] in_imm, rf_rdata1, rf_rdata2, ex_data, wb_data;
  logic        ex_fwd_en, ex_load_pend, wb_en, flush;
  logic        out_valid, out_ready, out_is_load;
  logic [31:0] out_op1, out_op2, out_imm;
  logic [15:0] stall_count;

  typedef struct {
    logic [31:0] op1, op2, imm;
    logic [4:0]  rd, rs1, rs2;
    logic        ld, u1, u2;
  } ent_t;

  ent_t        sb[$];
  logic [15:0] m_stall;
  logic        rdy_exp, rdy_got;
  int          checks = 0;
  int          failures = 0;

  operand_stage #(.XLEN(32), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_is_load(in_is_load),
    .in_imm(in_imm), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_fwd_en(ex_fwd_en), .ex_load_pend(ex_load_pend), .ex_rd(ex_rd), .ex_data(ex_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2),
    .out_imm(out_imm), .out_rd(out_rd), .out_is_load(out_is_load), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] res(input logic [4:0] s, input logic [31:0] rf);
    if (s == 5'd0) return 32'd0;
    if (ex_fwd_en && ex_rd == s) return ex_data;
    if (wb_en && wb_rd == s) return wb_data;
    return rf;
  endfunction

  task automatic idle();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_use_rs1 = 0; in_use_rs2 = 0;
    in_is_load = 0; in_imm = 0; rf_rdata1 = 0; rf_rdata2 = 0;
    ex_fwd_en = 0; ex_load_pend = 0; ex_rd = 0; ex_data = 0;
    wb_en = 0; wb_rd = 0; wb_data = 0; flush = 0; out_ready = 1;
  endtask

  task automatic instr(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] imm);
    in_valid = 1; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_use_rs1 = u1; in_use_rs2 = u2;
    rf_rdata1 = d1; rf_rdata2 = d2; in_imm = imm;
  endtask

  // One clock: model the edge from current inputs, leave time just after the next negedge.
  task automatic step();
    logic hz_m;
    ent_t e, h;
    #1;
    hz_m = in_valid & ex_load_pend & (ex_rd != 0) &
           ((in_use_rs1 & (ex_rd == in_rs1)) | (in_use_rs2 & (ex_rd == in_rs2)));
    rdy_exp = ~flush & ~hz_m & ((sb.size() == 0) | out_ready);
    rdy_got = in_ready;
    e.op1 = res(in_rs1, rf_rdata1); e.op2 = res(in_rs2, rf_rdata2); e.imm = in_imm;
    e.rd = in_rd; e.rs1 = in_rs1; e.rs2 = in_rs2; e.ld = in_is_load;
    e.u1 = in_use_rs1; e.u2 = in_use_rs2;
    if (hz_m && !flush && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    if (flush) sb.delete();
    else if (in_valid && rdy_exp) begin
      if (sb.size() != 0) void'(sb.pop_front());
      sb.push_back(e);
    end else if (sb.size() != 0 && out_ready) void'(sb.pop_front());
    else if (sb.size() != 0) begin
      h = sb[0];
      if (wb_en && wb_rd != 0 && h.u1 && wb_rd == h.rs1) h.op1 = wb_data;
      if (wb_en && wb_rd != 0 && h.u2 && wb_rd == h.rs2) h.op2 = wb_data;
      sb[0] = h;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle(); rst = 1; m_stall = 0; sb.delete();
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if ({out_op1, out_op2, out_imm} !== 96'd0) begin failures++; $display("FAIL reset_ops got=%h %h %h exp=0", out_op1, out_op2, out_imm); end
    checks++; if (out_rd !== 5'd0 || out_is_load !== 1'b0 || stall_count !== 16'd0) begin failures++; $display("FAIL reset_misc got=%0d %b %0d exp=0", out_rd, out_is_load, stall_count); end
    rst = 0;
  endtask

  task automatic test_basic();
    idle(); instr(5, 6, 8, 1, 1, 32'h11, 32'h22, 32'h123); in_is_load = 1;
    step();
    checks++; if (rdy_got !== rdy_exp) begin failures++; $display("FAIL basic_ready got=%b exp=%b", rdy_got, rdy_exp); end
    checks++; if (out_valid !== 1'b1 || out_op1 !== sb[0].op1 || out_op2 !== sb[0].op2) begin failures++; $display("FAIL basic_ops got=%b %h %h exp=1 %h %h", out_valid, out_op1, out_op2, sb[0].op1, sb[0].op2); end
    checks++; if (out_imm !== sb[0].imm || out_rd !== sb[0].rd || out_is_load !== sb[0].ld) begin failures++; $display("FAIL basic_fields got=%h %0d %b exp=%h %0d %b", out_imm, out_rd, out_is_load, sb[0].imm, sb[0].rd, sb[0].ld); end
    idle(); step();
    checks++; if (out_valid !== (sb.size() != 0)) begin failures++; $display("FAIL basic_drain got=%b exp=%b", out_valid, sb.size() != 0); end
  endtask

  task automatic test_forward();
    idle(); instr(7, 2, 1, 1, 1, 32'hCC, 32'hDD, 0);
    ex_fwd_en = 1; ex_rd = 7; ex_data = 32'hAA; wb_en = 1; wb_rd = 7; wb_data = 32'hBB;
    step();
    checks++; if (out_op1 !== sb[0].op1 || out_op2 !== sb[0].op2) begin failures++; $display("FAIL fwd_ex got=%h %h exp=%h %h", out_op1, out_op2, sb[0].op1, sb[0].op2); end
    ex_fwd_en = 0; in_rs2 = 7; step();
    checks++; if (out_op1 !== sb[0].op1 || out_op2 !== sb[0].op2) begin failures++; $display("FAIL fwd_wb got=%h %h exp=%h %h", out_op1, out_op2, sb[0].op1, sb[0].op2); end
    wb_en = 0; step();
    checks++; if (out_op1 !== sb[0].op1) begin failures++; $display("FAIL fwd_rf got=%h exp=%h", out_op1, sb[0].op1); end
    idle(); step();
  endtask

  task automatic test_load_use();
    idle(); instr(1, 2, 4, 1, 1, 32'h1, 32'h2, 0); step();
    instr(4, 3, 5, 0, 1, 32'h7, 32'h9, 32'h5); ex_load_pend = 1; ex_rd = 3;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (rdy_got !== rdy_exp) begin failures++; $display("FAIL lu_ready%0d got=%b exp=%b", i, rdy_got, rdy_exp); end
      checks++; if (out_valid !== (sb.size() != 0)) begin failures++; $display("FAIL lu_bubble%0d got=%b exp=%b", i, out_valid, sb.size() != 0); end
    end
    checks++; if (stall_count !== m_stall) begin failures++; $display("FAIL lu_count got=%0d exp=%0d", stall_count, m_stall); end
    ex_load_pend = 0; step();
    checks++; if (rdy_got !== rdy_exp || out_valid !== 1'b1 || out_op2 !== sb[0].op2) begin failures++; $display("FAIL lu_release got=%b %b %h exp=%b 1 %h", rdy_got, out_valid, out_op2, rdy_exp, sb[0].op2); end
    idle(); step();
  endtask

  task automatic test_hold_refresh();
    idle(); out_ready = 0; instr(9, 10, 12, 1, 0, 32'h33, 32'h44, 32'h77); step();
    instr(1, 1, 1, 1, 1, 0, 0, 0); wb_en = 1; wb_rd = 9; wb_data = 32'h55; step();
    checks++; if (rdy_got !== rdy_exp) begin failures++; $display("FAIL hold_ready got=%b exp=%b", rdy_got, rdy_exp); end
    checks++; if (out_op1 !== sb[0].op1 || out_op2 !== sb[0].op2) begin failures++; $display("FAIL hold_refresh got=%h %h exp=%h %h", out_op1, out_op2, sb[0].op1, sb[0].op2); end
    checks++; if (out_valid !== 1'b1 || out_imm !== sb[0].imm || out_rd !== sb[0].rd) begin failures++; $display("FAIL hold_stable got=%b %h %0d exp=1 %h %0d", out_valid, out_imm, out_rd, sb[0].imm, sb[0].rd); end
    wb_rd = 10; wb_data = 32'h66; ex_fwd_en = 1; ex_rd = 9; ex_data = 32'h99; step();
    checks++; if (out_op1 !== sb[0].op1 || out_op2 !== sb[0].op2) begin failures++; $display("FAIL hold_norefresh got=%h %h exp=%h %h", out_op1, out_op2, sb[0].op1, sb[0].op2); end
    idle(); step();
  endtask

  task automatic test_x0_flush();
    idle(); instr(0, 0, 3, 1, 1, 32'h12, 32'h34, 0);
    ex_fwd_en = 1; ex_rd = 0; ex_data = 32'hFF; wb_en = 1; wb_rd = 0; wb_data = 32'hEE; step();
    checks++; if (out_op1 !== sb[0].op1 || out_op2 !== sb[0].op2) begin failures++; $display("FAIL x0 got=%h %h exp=%h %h", out_op1, out_op2, sb[0].op1, sb[0].op2); end
    idle(); out_ready = 0; instr(1, 2, 6, 1, 1, 32'h5, 32'h6, 32'h8); flush = 1; step();
    checks++; if (rdy_got !== rdy_exp) begin failures++; $display("FAIL flush_ready got=%b exp=%b", rdy_got, rdy_exp); end
    checks++; if (out_valid !== (sb.size() != 0)) begin failures++; $display("FAIL flush_valid got=%b exp=%b", out_valid, sb.size() != 0); end
    idle(); step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_nocapture got=%b exp=0", out_valid); end
  endtask

  task automatic test_saturation();
    idle(); instr(3, 0, 1, 1, 0, 0, 0, 0); ex_load_pend = 1; ex_rd = 3;
    for (int i = 0; i < 65539; i++) step();
    checks++; if (stall_count !== 16'hFFFF) begin failures++; $display("FAIL stall_sat got=%h exp=ffff", stall_count); end
    flush = 1; step();
    checks++; if (stall_count !== m_stall) begin failures++; $display("FAIL stall_flush got=%h exp=%h", stall_count, m_stall); end
    idle(); step();
  endtask

  task automatic test_async_reset();
    idle(); out_ready = 0; instr(2, 3, 7, 1, 1, 32'hA5, 32'h5A, 32'hC3); in_is_load = 1; step();
    checks++; if (out_valid !== 1'b1 || out_op1 !== sb[0].op1) begin failures++; $display("FAIL ar_setup got=%b %h exp=1 %h", out_valid, out_op1, sb[0].op1); end
    #2 rst = 1;
    #1;
    checks++; if (out_valid !== 1'b0 || {out_op1, out_op2, out_imm} !== 96'd0) begin failures++; $display("FAIL ar_ops got=%b %h %h %h exp=0", out_valid, out_op1, out_op2, out_imm); end
    checks++; if (out_rd !== 5'd0 || out_is_load !== 1'b0 || stall_count !== 16'd0) begin failures++; $display("FAIL ar_misc got=%0d %b %0d exp=0", out_rd, out_is_load, stall_count); end
    sb.delete(); m_stall = 0;
    @(negedge clk); rst = 0; idle(); step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ar_nocapture got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_forward();
    test_load_use();
    test_hold_refresh();
    test_x0_flush();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
